// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side uses the master modport. The hazard controller uses the slave modport.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       rs1D_i;
   logic [4:0]       rs2D_i;
   logic [4:0]       rs1E_i;
   logic [4:0]       rs2E_i;
   logic [4:0]       rdE_i;
   logic [4:0]       rdM_i;
   logic [4:0]       rdW_i;
   logic             MemReadE_i;
   logic             RegWriteM_i;
   logic             RegWriteW_i;
   logic             PCSrcE_i;
   logic             memReq_i;
   logic             memReady_i;
   logic [1:0]       ForwardAE_o;
   logic [1:0]       ForwardBE_o;
   logic             StallF_o;
   logic             StallD_o;
   logic             StallE_o;
   logic             StallM_o;
   logic             FlushD_o;
   logic             FlushE_o;
   logic             FlushW_o;
   logic             memErr_o;
   logic [CNT_W-1:0] stallCnt_o;
   logic [CNT_W-1:0] flushCnt_o;

   modport master (
      output rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, rdM_i, rdW_i,
      output MemReadE_i, RegWriteM_i, RegWriteW_i, PCSrcE_i, memReq_i, memReady_i,
      input  ForwardAE_o, ForwardBE_o, StallF_o, StallD_o, StallE_o, StallM_o,
      input  FlushD_o, FlushE_o, FlushW_o, memErr_o, stallCnt_o, flushCnt_o
   );

   modport slave (
      input  rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, rdM_i, rdW_i,
      input  MemReadE_i, RegWriteM_i, RegWriteW_i, PCSrcE_i, memReq_i, memReady_i,
      output ForwardAE_o, ForwardBE_o, StallF_o, StallD_o, StallE_o, StallM_o,
      output FlushD_o, FlushE_o, FlushW_o, memErr_o, stallCnt_o, flushCnt_o
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV32I pipeline.
// It generates the combinational stall, flush and forward controls.
// It sequences multi-cycle data-memory accesses and runs a watchdog on them.
// It counts stall and redirect events with saturating counters.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input logic          clk_i,
   input logic          rst_i,
   hazard_ctrl_if.slave bus
);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   // The watchdog stops counting at MEM_TIMEOUT-1. The next stalled cycle raises the error.
   localparam logic [15:0]      WD_LAST = 16'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   state_t           state_next;
   logic             mem_wait;
   logic             lw_stall;
   logic             redirect;
   logic             stall_f;
   logic             stall_d;
   logic             stall_e;
   logic             stall_m;
   logic             flush_d;
   logic             flush_e;
   logic             flush_w;
   logic [15:0]      wd_cnt;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Forward select for one EX source operand. The MEM stage is younger, so it beats WB. x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic       wr_m,
                                          input logic [4:0] rd_m,
                                          input logic       wr_w,
                                          input logic [4:0] rd_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
         sel = 2'b10;
      else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
         sel = 2'b01;
      return sel;
   endfunction

   assign mem_wait = bus.memReq_i & ~bus.memReady_i;
   assign lw_stall = bus.MemReadE_i & (bus.rdE_i != 5'd0) &
                     ((bus.rdE_i == bus.rs1D_i) | (bus.rdE_i == bus.rs2D_i));

   // Operand forwarding selects. They stay at the register-file source while reset is held.
   always_comb begin
      bus.ForwardAE_o = 2'b00;
      bus.ForwardBE_o = 2'b00;
      if (!rst_i) begin
         bus.ForwardAE_o = fwd_sel(bus.rs1E_i, bus.RegWriteM_i, bus.rdM_i, bus.RegWriteW_i, bus.rdW_i);
         bus.ForwardBE_o = fwd_sel(bus.rs2E_i, bus.RegWriteM_i, bus.rdM_i, bus.RegWriteW_i, bus.rdW_i);
      end
   end

   // Prioritised stall and flush controls.
   // A memory wait freezes EX, so a redirect or load-use in EX waits for the release cycle.
   always_comb begin
      // NOTE: every output gets a default first, so no path through the if-chain leaves one unassigned and infers a latch.
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      stall_m  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      flush_w  = 1'b0;
      redirect = 1'b0;
      if (rst_i) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
         flush_w = 1'b1;
      end else if (mem_wait) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else if (bus.PCSrcE_i) begin
         flush_d  = 1'b1;
         flush_e  = 1'b1;
         redirect = 1'b1;
      end else if (lw_stall) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   // Memory access sequencer next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         RUN:      if (bus.memReq_i && !bus.memReady_i) state_next = MEM_WAIT;
         MEM_WAIT: if (bus.memReady_i)                  state_next = RUN;
         default:                                       state_next = RUN;
      endcase
   end

   // Memory access sequencer state register.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      if (rst_i) state <= RUN;
      else       state <= state_next;
   end

   // Watchdog on stalled memory cycles. The error is sticky until reset and does not abort the access.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wd_cnt  <= '0;
         mem_err <= 1'b0;
      end else if ((state == MEM_WAIT) && !bus.memReady_i) begin
         if (wd_cnt >= WD_LAST) mem_err <= 1'b1;
         else                   wd_cnt  <= wd_cnt + 16'd1;
      end else begin
         wd_cnt <= '0;
      end
   end

   // Saturating event counters: stalled fetch cycles, and taken redirects that won priority.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_f && (stall_cnt != CNT_MAX))  stall_cnt <= stall_cnt + 1'b1;
         if (redirect && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign bus.StallF_o   = stall_f;
   assign bus.StallD_o   = stall_d;
   assign bus.StallE_o   = stall_e;
   assign bus.StallM_o   = stall_m;
   assign bus.FlushD_o   = flush_d;
   assign bus.FlushE_o   = flush_e;
   assign bus.FlushW_o   = flush_w;
   assign bus.memErr_o   = mem_err;
   assign bus.stallCnt_o = stall_cnt;
   assign bus.flushCnt_o = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl.
// Each cycle's expected outputs are pushed to a scoreboard when the inputs are driven.
// The entry is popped and compared at the falling edge.
module tb_hazard_ctrl;

   localparam int TO   = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct packed {
      logic [1:0]    fa;
      logic [1:0]    fb;
      logic          sf, sd, se, sm;
      logic          fd, fe, fw;
      logic          err;
      logic [CW-1:0] scnt;
      logic [CW-1:0] fcnt;
   } obs_t;

   typedef struct {
      obs_t  o;
      bit    chk_reg;
      string tag;
   } sb_t;

   logic clk = 1'b0;
   logic rst;

   hazard_ctrl_if #(.CNT_W(CW)) bus ();

   hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   sb_t  sb_q[$];
   int   n_total = 0;
   int   n_bad   = 0;
   obs_t last;

   // Reference state, independent of the RTL
   bit m_known = 1'b0;
   bit m_wait  = 1'b0;
   int m_wd    = 0;
   bit m_err   = 1'b0;
   int m_scnt  = 0;
   int m_fcnt  = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
      if (bus.RegWriteM_i && bus.rdM_i != 0 && bus.rdM_i == rs) return 2'b10;
      if (bus.RegWriteW_i && bus.rdW_i != 0 && bus.rdW_i == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic obs_t predict();
      obs_t o;
      bit   mw, lw;
      o    = '0;
      mw   = bus.memReq_i && !bus.memReady_i;
      lw   = bus.MemReadE_i && bus.rdE_i != 0 &&
             (bus.rdE_i == bus.rs1D_i || bus.rdE_i == bus.rs2D_i);
      if (rst) begin
         {o.fd, o.fe, o.fw} = 3'b111;
      end else begin
         o.fa = ref_fwd(bus.rs1E_i);
         o.fb = ref_fwd(bus.rs2E_i);
         if (mw)                  {o.sf, o.sd, o.se, o.sm, o.fw} = 5'b11111;
         else if (bus.PCSrcE_i)   {o.fd, o.fe} = 2'b11;
         else if (lw)             {o.sf, o.sd, o.fe} = 3'b111;
      end
      o.err  = m_err;
      o.scnt = CW'(m_scnt);
      o.fcnt = CW'(m_fcnt);
      return o;
   endfunction

   task automatic idle();
      bus.rs1D_i = 0; bus.rs2D_i = 0; bus.rs1E_i = 0; bus.rs2E_i = 0;
      bus.rdE_i = 0; bus.rdM_i = 0; bus.rdW_i = 0;
      bus.MemReadE_i = 0; bus.RegWriteM_i = 0; bus.RegWriteW_i = 0;
      bus.PCSrcE_i = 0; bus.memReq_i = 0; bus.memReady_i = 0;
   endtask

   // One clock cycle. The inputs are already driven (just after a rising edge).
   task automatic step(input string tag);
      sb_t e;
      bit  redirect;
      e.o = predict();
      e.chk_reg = m_known;
      e.tag = tag;
      sb_q.push_back(e);
      @(negedge clk);
      e = sb_q.pop_front();
      last.fa = bus.ForwardAE_o;  last.fb = bus.ForwardBE_o;
      last.sf = bus.StallF_o;     last.sd = bus.StallD_o;
      last.se = bus.StallE_o;     last.sm = bus.StallM_o;
      last.fd = bus.FlushD_o;     last.fe = bus.FlushE_o;
      last.fw = bus.FlushW_o;     last.err = bus.memErr_o;
      last.scnt = bus.stallCnt_o; last.fcnt = bus.flushCnt_o;
      check({e.tag, ".fwdA"}, 32'(last.fa), 32'(e.o.fa));
      check({e.tag, ".fwdB"}, 32'(last.fb), 32'(e.o.fb));
      check({e.tag, ".stall"}, 32'({last.sf, last.sd, last.se, last.sm}),
                               32'({e.o.sf, e.o.sd, e.o.se, e.o.sm}));
      check({e.tag, ".flush"}, 32'({last.fd, last.fe, last.fw}), 32'({e.o.fd, e.o.fe, e.o.fw}));
      if (e.chk_reg) begin
         check({e.tag, ".memErr"}, 32'(last.err), 32'(e.o.err));
         check({e.tag, ".stallCnt"}, 32'(last.scnt), 32'(e.o.scnt));
         check({e.tag, ".flushCnt"}, 32'(last.fcnt), 32'(e.o.fcnt));
      end
      // Advance the reference model across the coming rising edge
      redirect = !rst && !(bus.memReq_i && !bus.memReady_i) && bus.PCSrcE_i;
      if (rst) begin
         m_known = 1; m_wait = 0; m_wd = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
      end else begin
         if (e.o.sf && m_scnt < CMAX) m_scnt++;
         if (redirect && m_fcnt < CMAX) m_fcnt++;
         if (m_wait && !bus.memReady_i) begin
            m_wd++;
            if (m_wd >= TO) m_err = 1;
         end else begin
            m_wd = 0;
         end
         m_wait = m_wait ? !bus.memReady_i : (bus.memReq_i && !bus.memReady_i);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      step("rst");
      rst = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL sim_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      idle();
      rst = 1;
      @(posedge clk); #1;
      // Reset with active hazards present: only the flushes may assert
      bus.memReq_i = 1; bus.PCSrcE_i = 1; bus.RegWriteM_i = 1; bus.rdM_i = 3; bus.rs1E_i = 3;
      step("reset0");
      step("reset1");
      check("reset_fwdA", 32'(last.fa), 0);
      check("reset_flushes", 32'({last.fd, last.fe, last.fw}), 32'h7);
      check("reset_stallF", 32'(last.sf), 0);
      idle(); rst = 0;
      step("post_reset");
      check("post_reset_cnt", 32'({last.scnt, last.fcnt}), 0);

      // Forwarding
      bus.RegWriteM_i = 1; bus.rdM_i = 5; bus.RegWriteW_i = 1; bus.rdW_i = 5;
      bus.rs1E_i = 5; bus.rs2E_i = 6;
      step("fwd_mem_wins");
      check("fwd_mem_wins_A", 32'(last.fa), 32'h2);
      check("fwd_mem_wins_B", 32'(last.fb), 32'h0);
      bus.rdM_i = 0;
      step("fwd_wb");
      check("fwd_wb_A", 32'(last.fa), 32'h1);
      bus.RegWriteM_i = 0; bus.rdM_i = 6; bus.rdW_i = 6;
      step("fwd_gate_wr");
      check("fwd_gate_wr_B", 32'(last.fb), 32'h1);
      bus.RegWriteM_i = 1; bus.rdM_i = 0; bus.rdW_i = 0; bus.rs1E_i = 0; bus.rs2E_i = 0;
      step("fwd_x0");
      check("fwd_x0_AB", 32'({last.fa, last.fb}), 0);

      // Load-use: exactly one bubble
      do_reset();
      bus.MemReadE_i = 1; bus.rdE_i = 7; bus.rs2D_i = 7;
      step("lw_use");
      check("lw_use_ctl", 32'({last.sf, last.sd, last.fe}), 32'h7);
      idle();
      step("lw_after");
      check("lw_after_stallF", 32'(last.sf), 0);
      check("lw_after_cnt", 32'(last.scnt), 1);
      bus.MemReadE_i = 1; bus.rdE_i = 0; bus.rs1D_i = 0;
      step("lw_x0");

      // Branch overrides load-use
      do_reset();
      bus.PCSrcE_i = 1; bus.MemReadE_i = 1; bus.rdE_i = 7; bus.rs1D_i = 7;
      step("br_lw");
      check("br_lw_flush", 32'({last.fd, last.fe, last.sf}), 32'h6);
      idle();
      step("br_after");
      check("br_after_cnt", 32'({last.fcnt, last.scnt}), 32'(1 << CW));

      // Memory wait with a redirect held throughout
      do_reset();
      bus.memReq_i = 1; bus.PCSrcE_i = 1;
      for (int i = 0; i < 3; i++) begin
         step("mwait");
         check("mwait_ctl", 32'({last.sf, last.sd, last.se, last.sm, last.fw, last.fd, last.fe}), 32'h7C);
      end
      bus.memReady_i = 1;
      step("mwait_release");
      check("mwait_release_stall", 32'(last.sf), 0);
      idle();
      step("mwait_after");
      check("mwait_after_cnt", 32'(last.scnt), 3);
      bus.memReq_i = 1; bus.memReady_i = 1;
      step("mem_ready_now");
      check("mem_ready_now_stall", 32'(last.sf), 0);

      // Watchdog: 1 RUN cycle then MEM_WAIT cycles with memReady low
      do_reset();
      bus.memReq_i = 1;
      for (int i = 0; i < 5; i++) step("wd_hold");
      check("wd_before", 32'(last.err), 0);
      step("wd_hold");
      check("wd_set", 32'(last.err), 1);
      bus.memReady_i = 1;
      step("wd_release");
      idle();
      step("wd_sticky");
      check("wd_sticky", 32'(last.err), 1);
      do_reset();
      step("wd_cleared");
      check("wd_cleared", 32'({last.err, last.scnt, last.fcnt}), 0);

      // Reset asserted during MEM_WAIT
      bus.memReq_i = 1;
      step("rmw_enter");
      step("rmw_wait");
      rst = 1;
      step("rmw_rst");
      check("rmw_rst_ctl", 32'({last.fd, last.fe, last.fw, last.sf, last.sm}), 32'h1C);
      rst = 0; idle();
      step("rmw_idle");
      check("rmw_idle_stall", 32'({last.sf, last.sd, last.se, last.sm}), 0);
      bus.memReq_i = 1;
      for (int i = 0; i < 6; i++) step("rmw_rewait");
      idle(); bus.memReq_i = 1; bus.memReady_i = 1;
      step("rmw_done");

      // Counter saturation
      do_reset();
      bus.MemReadE_i = 1; bus.rdE_i = 9; bus.rs1D_i = 9;
      for (int i = 0; i < CMAX + 3; i++) step("sat_stall");
      idle(); bus.PCSrcE_i = 1;
      for (int i = 0; i < CMAX + 3; i++) step("sat_flush");
      idle();
      step("sat_done");
      check("sat_cnts", 32'({last.scnt, last.fcnt}), 32'hFF);

      // Random mix with heavy register aliasing and x0
      do_reset();
      for (int i = 0; i < 200; i++) begin
         bus.rs1D_i = 5'($urandom_range(0, 3)); bus.rs2D_i = 5'($urandom_range(0, 3));
         bus.rs1E_i = 5'($urandom_range(0, 3)); bus.rs2E_i = 5'($urandom_range(0, 3));
         bus.rdE_i  = 5'($urandom_range(0, 3)); bus.rdM_i  = 5'($urandom_range(0, 3));
         bus.rdW_i  = 5'($urandom_range(0, 3));
         bus.MemReadE_i  = 1'($urandom_range(0, 1));
         bus.RegWriteM_i = 1'($urandom_range(0, 1));
         bus.RegWriteW_i = 1'($urandom_range(0, 1));
         bus.PCSrcE_i    = ($urandom_range(0, 3) == 0);
         bus.memReq_i    = 1'($urandom_range(0, 1));
         bus.memReady_i  = ($urandom_range(0, 3) != 0);
         rst             = ($urandom_range(0, 31) == 0);
         step("rand");
      end
      rst = 0; idle();
      step("final");

      check("scoreboard_empty", 32'(sb_q.size()), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
